// File: rtl/ps2_byte_if.sv
// rtl/ps2_byte_if.sv - byte stream from the PS/2 receiver into the key decoder
interface ps2_byte_if;
  logic       rx_done_tick;
  logic [7:0] rx_data;

  modport master (output rx_done_tick, output rx_data);
  modport slave  (input  rx_done_tick, input  rx_data);
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - scan-code set 2 decoder with held-key bitmap and player directions
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int CNT_W          = 22
) (
  input  logic             clk,
  input  logic             reset,
  ps2_byte_if.slave        rx,
  output logic             key_event,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic [7:0]       key_down,
  output logic [1:0]       p1_dir,
  output logic [1:0]       p2_dir,
  output logic             dir_change_tick,
  output logic             pause_tick
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             is_e0, is_f0;
  logic             done, done_ext, done_brk;
  logic             map_hit;
  logic [2:0]       map_idx;
  logic [1:0]       cur_dir, req_dir;
  logic             dir_ok;

  assign is_e0 = (rx.rx_data == 8'hE0);
  assign is_f0 = (rx.rx_data == 8'hF0);

  // Prefix sequencing: a byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    done_ext = 1'b0;
    done_brk = 1'b0;
    if (rx.rx_done_tick) begin
      case (state)
        IDLE: begin
          if (is_e0)      state_nx = EXT;
          else if (is_f0) state_nx = BRK;
          else            done     = 1'b1;
        end
        EXT: begin
          if (is_f0)      state_nx = EXT_BRK;
          else if (!is_e0) begin
            done     = 1'b1;
            done_ext = 1'b1;
            state_nx = IDLE;
          end
        end
        BRK: begin
          if (is_e0)      state_nx = EXT;
          else if (!is_f0) begin
            done     = 1'b1;
            done_brk = 1'b1;
            state_nx = IDLE;
          end
        end
        EXT_BRK: begin
          if (!is_e0 && !is_f0) begin
            done     = 1'b1;
            done_ext = 1'b1;
            done_brk = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end else if (state != IDLE && cnt == CNT_LAST) begin
      state_nx = IDLE;
    end
  end

  // Key map: bitmap index doubles as direction (low two bits) and player select (bit 2).
  always_comb begin
    map_hit = 1'b1;
    map_idx = 3'd0;
    case ({done_ext, rx.rx_data})
      9'h01D:  map_idx = 3'd0;
      9'h023:  map_idx = 3'd1;
      9'h01B:  map_idx = 3'd2;
      9'h01C:  map_idx = 3'd3;
      9'h175:  map_idx = 3'd4;
      9'h174:  map_idx = 3'd5;
      9'h172:  map_idx = 3'd6;
      9'h16B:  map_idx = 3'd7;
      default: map_hit = 1'b0;
    endcase
  end

  // Direction request is accepted only on a make that is neither a repeat nor a reversal.
  always_comb begin
    cur_dir = map_idx[2] ? p2_dir : p1_dir;
    req_dir = map_idx[1:0];
    dir_ok  = done && !done_brk && map_hit &&
              (req_dir != cur_dir) && (req_dir != (cur_dir ^ 2'b10));
  end

  // FSM state and prefix idle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (rx.rx_done_tick || state == IDLE) cnt <= '0;
      else                                  cnt <= cnt + 1'b1;
    end
  end

  // Registered key event, held bitmap, directions and ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_event       <= 1'b0;
      key_code        <= 8'h00;
      key_ext         <= 1'b0;
      key_break       <= 1'b0;
      key_down        <= 8'h00;
      p1_dir          <= 2'b01;
      p2_dir          <= 2'b11;
      dir_change_tick <= 1'b0;
      pause_tick      <= 1'b0;
    end else begin
      key_event       <= done;
      dir_change_tick <= dir_ok;
      pause_tick      <= done && !done_ext && !done_brk && (rx.rx_data == 8'h76);
      if (done) begin
        key_code  <= rx.rx_data;
        key_ext   <= done_ext;
        key_break <= done_brk;
        if (map_hit) key_down[map_idx] <= !done_brk;
      end
      if (dir_ok) begin
        if (map_idx[2]) p2_dir <= req_dir;
        else            p1_dir <= req_dir;
      end
    end
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the byte stream from the PS/2 receiver (`rx_data` qualified by `rx_done_tick`) and decodes scan-code set 2 sequences, including the E0 extended prefix and the F0 break prefix, into complete key events. It maintains a held-key bitmap for the eight TRON control keys and two registered player directions, with 180° reversal rejection. It sits between the PS/2 receiver and the game-control FSM.

## Interface
- `TIMEOUT_CYCLES`, default 2_500_000: idle clocks allowed inside a prefix sequence before resync (50 ms at 50 MHz).
- `CNT_W`, default 22: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `rx_done_tick`  in  1  one-cycle strobe: `rx_data` holds a new byte.
- `rx_data`  in  8  received byte.
- `key_event`  out  1  one-cycle pulse per completed scan code (make or break, mapped or not).
- `key_code`  out  8  final byte of the last completed code.
- `key_ext`  out  1  last code carried the E0 prefix.
- `key_break`  out  1  last code carried the F0 prefix.
- `key_down`  out  8  held bitmap, 1 = held: [0] W, [1] D, [2] S, [3] A, [4] Up, [5] Right, [6] Down, [7] Left.
- `p1_dir`  out  2  player 1 direction: 00 up, 01 right, 10 down, 11 left.
- `p2_dir`  out  2  player 2 direction, same encoding.
- `dir_change_tick`  out  1  one-cycle pulse when `p1_dir` or `p2_dir` changes.
- `pause_tick`  out  1  one-cycle pulse on an Esc make (non-extended 76).

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen). Transitions occur only on `rx_done_tick`, except on timeout.
- IDLE: E0 goes to EXT. F0 goes to BRK. Any other byte completes a non-extended make and stays in IDLE.
- EXT: F0 goes to EXT_BRK. E0 stays in EXT. Any other byte completes an extended make and returns to IDLE.
- BRK: F0 stays in BRK. E0 goes to EXT, discarding the break. Any other byte completes a non-extended break and returns to IDLE.
- EXT_BRK: E0 or F0 stays in EXT_BRK. Any other byte completes an extended break and returns to IDLE.
- Completed code: `key_code`, `key_ext`, and `key_break` are loaded, and `key_event` pulses.
- Key map, non-extended: 1D W, 23 D, 1B S, 1C A. Key map, extended: 75 Up, 74 Right, 72 Down, 6B Left. The same byte with the wrong `key_ext` is unmapped.
- A make sets the mapped `key_down` bit. A break clears it. Unmapped codes change no state other than the `key_*` outputs.
- Direction updates happen on a make only:
  - W/D/S/A set `p1_dir` to 00/01/10/11.
  - Up/Right/Down/Left set `p2_dir` to 00/01/10/11.
  - A request equal to `cur ^ 2'b10` (reversal) is ignored.
  - A request equal to `cur` (typematic repeat) causes no change and no `dir_change_tick`.
- A direction update applies in the same cycle as the `key_down` update. `dir_change_tick` pulses only if a value actually changed.
- Timeout: in any non-IDLE state, a counter increments each clock without `rx_done_tick`. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE with no event. The counter clears on every `rx_done_tick` and whenever the FSM is in IDLE.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `key_event`, `dir_change_tick`, `pause_tick` = 0.
  - `key_code` 00, `key_ext` 0, `key_break` 0, `key_down` 00.
  - `p1_dir` 01 (right), `p2_dir` 11 (left).
- All outputs are registered. The final byte's `rx_done_tick` at cycle N produces `key_event`, `key_down`, the direction outputs, and the ticks at cycle N+1.
- Prefix bytes produce no output change.
- Back-to-back `rx_done_tick` on consecutive cycles must be handled; each byte is processed exactly once.
- Reset asserted mid-sequence returns the FSM to IDLE immediately. A following data byte is then treated as a fresh make.
- The timeout is measured from the last prefix byte's tick. A byte arriving on the expiry cycle wins: it is decoded and the timeout is not taken.

## Test plan
- Bytes 1D, then F0 1D -> first completion: `key_event` with code 1D, ext 0, brk 0; `key_down[0]`=1; `p1_dir` stays 00→ from reset 01 changes to 00 with `dir_change_tick`. Second completion: brk 1 and `key_down[0]`=0.
- E0 74 from reset (`p2_dir`=11) -> reversal (11^10=01) ignored: `p2_dir` stays 11, no `dir_change_tick`, `key_down[5]`=1. Then E0 75 -> `p2_dir`=00 with `dir_change_tick`.
- E0 F0 6B -> single `key_event` with code 6B, ext 1, brk 1; `key_down[7]` cleared. Plain 6B -> `key_event` with ext 0; `key_down` unchanged.
- Byte E0, then idle for TIMEOUT_CYCLES clocks (test with TIMEOUT_CYCLES=16), then 75 -> code 75 decoded as non-extended: `key_event` fires, `p2_dir` unchanged.
- Bytes 76, then 1D 1D 1D at back-to-back cycles -> `pause_tick` once; `key_event` three times; with `p1_dir` already 00, no `dir_change_tick`.
- Assert `reset` after byte F0 -> all outputs at reset values. Then 1C -> make: `key_down[3]`=1; `p1_dir` 01→11 is a reversal, so it stays 01.
